// File: rtl/fp_round_normalizer.sv
// Normalize-and-round stage: 12-bit sign-magnitude in, 8-bit {S,E[2:0],F[3:0]} out.
// Leading-one search shifts one bit per cycle; result leaves through a valid/ready handshake.
module fp_round_normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [11:0] mag_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  fp_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t      state;
    logic [11:0] m;
    logic [2:0]  e;
    logic        s;

    logic [3:0]  f;
    logic        r;
    logic [4:0]  f_inc;
    logic [3:0]  f_rnd;
    logic [2:0]  e_rnd;

    assign f        = m[10:7];
    assign r        = m[6];
    assign f_inc    = {1'b0, f} + 5'd1;
    assign in_ready = (state == IDLE);

    // Round half-up; a carry out of F renormalizes, or saturates at the top exponent.
    always_comb begin
        f_rnd = f;
        e_rnd = e;
        if (r) begin
            if (!f_inc[4]) begin
                f_rnd = f_inc[3:0];
            end else if (e != 3'd7) begin
                f_rnd = 4'd8;
                e_rnd = e + 3'd1;
            end else begin
                f_rnd = 4'd15;
                e_rnd = 3'd7;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m         <= 12'd0;
            e         <= 3'd0;
            s         <= 1'b0;
            out_valid <= 1'b0;
            fp_out    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m     <= mag_in;
                        s     <= sign_in;
                        e     <= 3'd7;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // m[11] is never set by upstream; treating it as normalized keeps the search bounded
                    if (m[11] || m[10] || e == 3'd0) begin
                        state <= ROUND;
                    end else begin
                        m <= {m[10:0], 1'b0};
                        e <= e - 3'd1;
                    end
                end
                ROUND: begin
                    fp_out    <= {s, e_rnd, f_rnd};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_round_normalizer.sv
// Directed-vector bench for fp_round_normalizer: result, latency, handshake and reset abort.
module tb_fp_round_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [11:0] mag_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  fp_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] res;
    int         lat;
    bit         ir_low;

    fp_round_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .mag_in    (mag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_out    (fp_out)
    );

    always #5 clk = ~clk;

    // Drive one input for a single accept edge; leaves time at 1 unit after that edge.
    task automatic do_accept(input logic [11:0] mag, input logic sgn);
        mag_in   = mag;
        sign_in  = sgn;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mag_in   = 12'h000;
        sign_in  = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid is seen (bounded), tracking in_ready.
    task automatic wait_valid(output int cycles, output bit ready_stayed_low, output logic [7:0] result);
        cycles = 0;
        ready_stayed_low = (in_ready == 1'b0);
        while (cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (in_ready !== 1'b0) ready_stayed_low = 1'b0;
            if (out_valid === 1'b1) break;
        end
        result = fp_out;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (fp_out !== 8'h00) begin bad++; $display("FAIL reset_fp_out got=%h want=00", fp_out); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_idle out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    // Convert with out_ready held high; checks result, latency, in_ready and return to IDLE.
    task automatic test_convert(input logic [11:0] mag, input logic sgn, input logic [7:0] want, input int want_lat, input string name);
        out_ready = 1'b1;
        do_accept(mag, sgn);
        wait_valid(lat, ir_low, res);
        total++; if (res !== want) begin bad++; $display("FAIL %s_value got=%h want=%h", name, res, want); end
        total++; if (lat !== want_lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, want_lat); end
        total++; if (!ir_low) begin bad++; $display("FAIL %s_in_ready_busy got=1 want=0 while converting", name); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL %s_handshake out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready); end
    endtask

    task automatic test_typical;
        test_convert(12'h1A6, 1'b0, 8'h5D, 4, "typical");
    endtask

    task automatic test_zero;
        test_convert(12'h000, 1'b0, 8'h00, 9, "zero");
    endtask

    task automatic test_rounding;
        test_convert(12'h07C, 1'b0, 8'h48, 6, "round_ovf");
        test_convert(12'h00F, 1'b0, 8'h0F, 9, "exact_e0");
        test_convert(12'h0C8, 1'b1, 8'hCD, 5, "round_up");
        test_convert(12'h0FF, 1'b0, 8'h58, 5, "round_ovf2");
        test_convert(12'h001, 1'b0, 8'h01, 9, "one");
    endtask

    task automatic test_saturation;
        test_convert(12'h7F8, 1'b1, 8'hFF, 2, "sat_7f8");
        test_convert(12'h7FF, 1'b1, 8'hFF, 2, "sat_7ff");
    endtask

    task automatic test_backpressure;
        logic [7:0] held;
        bit stable;
        out_ready = 1'b0;
        do_accept(12'h1A6, 1'b0);
        wait_valid(lat, ir_low, held);
        total++; if (held !== 8'h5D) begin bad++; $display("FAIL bp_value got=%h want=5D", held); end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                mag_in = 12'h7FF; sign_in = 1'b1; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (fp_out !== 8'h5D || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        total++; if (!stable) begin bad++; $display("FAIL bp_hold fp_out=%h out_valid=%b in_ready=%b want 5D/1/0", fp_out, out_valid, in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        test_convert(12'h0C8, 1'b0, 8'h4D, 5, "bp_next");
    endtask

    task automatic test_reset_mid_shift;
        out_ready = 1'b1;
        do_accept(12'h001, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
        total++; if (fp_out !== 8'h00) begin bad++; $display("FAIL abort_fp_out got=%h want=00", fp_out); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_no_result got=%b want=0", out_valid); end
        test_convert(12'h1A6, 1'b0, 8'h5D, 4, "after_abort");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        sign_in   = 1'b0;
        mag_in    = 12'h000;
        out_ready = 1'b1;
        test_reset;
        test_typical;
        test_zero;
        test_rounding;
        test_saturation;
        test_backpressure;
        test_reset_mid_shift;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
